// File: rtl/oc_uart_rx.sv
// 8N1 UART receiver: synchronizer, start-glitch rejection, mid-bit sampling,
// framing/overflow detection and a one-byte valid/ready output buffer.
module oc_uart_rx #(
    parameter int ClockHz    = 156250000,
    parameter int Baud       = 115200,
    parameter int SyncCycles = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uartRx,
    output logic [7:0] rxData,
    output logic       rxValid,
    input  logic       rxReady,
    output logic       framingError,
    output logic       overflowError,
    output logic       errorSticky,
    input  logic       errorClear,
    output logic       busy
);

    localparam int BitCycles = (ClockHz + Baud / 2) / Baud;
    localparam int HalfBit   = BitCycles / 2;
    localparam int CntW      = $clog2(BitCycles);

    localparam logic [CntW-1:0] BIT_LOAD  = CntW'(BitCycles - 1);
    localparam logic [CntW-1:0] HALF_LOAD = CntW'(HalfBit - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    if (BitCycles < 4) begin : g_bit_cycles_check
        $error("oc_uart_rx: BitCycles must be at least 4");
    end
    if (SyncCycles < 2 || SyncCycles > 4) begin : g_sync_cycles_check
        $error("oc_uart_rx: SyncCycles must be in 2..4");
    end

    logic [SyncCycles-1:0] sync_q;
    logic                  rx_s;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            framing_q, framing_d;
    logic            overflow_q, overflow_d;
    logic            sticky_q, sticky_d;
    logic            sample;
    logic            deliver;

    // Idle-high line: synchronizer resets to 1 so reset release is not a start edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SyncCycles-2:0], uartRx};
        end
    end

    assign rx_s   = sync_q[SyncCycles-1];
    assign sample = (cnt_q == '0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        framing_d  = 1'b0;
        overflow_d = 1'b0;
        deliver    = 1'b0;

        if (valid_q && rxReady) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    cnt_d   = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (!sample) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rx_s) begin
                    cnt_d     = BIT_LOAD;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!sample) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    cnt_d     = BIT_LOAD;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (!sample) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Re-arm at mid-stop-bit so a following start bit is never missed.
                    cnt_d = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        framing_d = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (deliver) begin
            if (!valid_q || rxReady) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        // Set wins over a simultaneous clear.
        sticky_d = (sticky_q && !errorClear) || framing_d || overflow_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            framing_q  <= 1'b0;
            overflow_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            framing_q  <= framing_d;
            overflow_q <= overflow_d;
            sticky_q   <= sticky_d;
        end
    end

    assign rxData        = data_q;
    assign rxValid       = valid_q;
    assign framingError  = framing_q;
    assign overflowError = overflow_q;
    assign errorSticky   = sticky_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: doc/oc_uart_rx.md
Name: oc_uart_rx

Overview:
- Receive half of the board UART path: consumes one asynchronous uartRx bit from the chip-top IBUF and produces 8-bit bytes on a valid/ready stream into the COS control logic.
- One instance per UART, on the top clock (clockRef[ClockTop]).
- Handles synchronization, start-bit glitch rejection, mid-bit sampling, framing errors, and one-byte output buffering with overflow detection.
- Frame format is fixed: 8N1, LSB first.

Parameters:
- ClockHz, 156250000, frequency of clock in Hz.
- Baud, 115200, line rate in bits per second.
- SyncCycles, 2, number of synchronizer flops on uartRx. Range 2..4.
- Derived localparam BitCycles = (ClockHz + Baud/2) / Baud, i.e. rounded to nearest. Static assert BitCycles >= 4.
- Derived localparam HalfBit = BitCycles / 2, truncated.

Ports:
- clock, input, 1, block clock.
- reset, input, 1, asynchronous active-high reset.
- uartRx, input, 1, raw serial line; idle high; asynchronous to clock.
- rxData, output, 8, received byte; held stable while rxValid=1.
- rxValid, output, 1, rxData holds an unconsumed byte.
- rxReady, input, 1, consumer accepts the byte on a cycle where rxValid && rxReady.
- framingError, output, 1, one-cycle pulse: stop bit sampled low.
- overflowError, output, 1, one-cycle pulse: a completed byte was dropped because the buffer was full.
- errorSticky, output, 1, set by either error pulse; cleared by errorClear.
- errorClear, input, 1, synchronous clear of errorSticky.
- busy, output, 1, FSM not in IDLE.

Behaviour:
- Reset values (asynchronous): all synchronizer flops = 1, FSM = IDLE, rxData = 0, rxValid = 0, framingError = 0, overflowError = 0, errorSticky = 0, busy = 0. Counters = 0.
- Synchronizer: uartRx passes through SyncCycles flops to form rxS. The FSM uses only rxS.
- Bit counter: down-counter, width clog2(BitCycles). A sample event occurs on the cycle the counter equals 0; the counter then reloads.
- FSM states:
  - IDLE: when rxS=0, load counter with HalfBit-1 and go to START.
  - START: at the sample event:
    - rxS=0: load BitCycles-1, bitIdx=0, go to DATA.
    - rxS=1: treat as a glitch, return to IDLE. No error is raised.
  - DATA: at each sample event, shift rxS into the shift register at the MSB and shift right (LSB first). Increment bitIdx and reload BitCycles-1. After the 8th sample, go to STOP.
  - STOP: at the sample event:
    - rxS=1: deliver the byte (see below), go to IDLE.
    - rxS=0: pulse framingError, set errorSticky, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxS=1, then go to IDLE. This prevents a break condition from producing repeated frames.
- Re-arming: IDLE is re-entered at mid-stop-bit, so back-to-back frames with a single stop bit are received with no gap.
- Delivery, registered on the cycle after the stop sample:
  - If rxValid=0, or rxValid && rxReady in that same cycle: rxData <= shifted byte, rxValid <= 1.
  - Otherwise: overflowError pulses, errorSticky sets, the new byte is dropped, and the held rxData/rxValid are unchanged.
- Handshake:
  - rxValid falls on the cycle after rxValid && rxReady, unless a simultaneous delivery reloads it.
  - rxReady with rxValid=0 has no effect.
  - rxData must not change while rxValid=1 and rxReady=0.
- Latency: the stop sample occurs SyncCycles + HalfBit + 9*BitCycles cycles after the first clock that sees uartRx low (±1). rxValid rises 1 cycle later.
- errorSticky: errorClear in the same cycle as an error pulse leaves errorSticky = 1, because set wins.
- reset asserted mid-frame: immediate return to reset values. The partial byte is lost and no error is flagged.
- Baud mismatch tolerance follows from mid-bit sampling: about ±4% cumulative at 8N1. No resynchronization occurs inside a frame.

Test Plan:
Use ClockHz=1000000 and Baud=100000, giving BitCycles=10 and HalfBit=5.
- Single byte: drive 0xA5 as 8N1 with rxReady=1. Expect rxData=0xA5 with a one-cycle rxValid, about 97 cycles after the start edge. No errors.
- Back-to-back: send 0x00, 0xFF, 0x3C with single stop bits and hold rxReady=0 until the first byte is valid, then 1. Expect all three bytes in order and no overflowError.
- Glitch: pulse uartRx low for 3 cycles. Expect FSM back to IDLE, rxValid=0, framingError=0.
- Framing: send 0x55 with the stop bit low and the line then held low for 40 cycles. Expect one framingError pulse, errorSticky=1, and no rxValid. After the line returns high, 0x12 is received correctly. Assert errorClear and expect errorSticky=0.
- Overflow: hold rxReady=0 and send 0x11 then 0x22. Expect rxData=0x11 held, one overflowError pulse at the second stop bit. Assert rxReady and expect 0x11 consumed and rxValid low.
- Reset mid-frame: assert reset during data bit 4 of 0x81. Expect all outputs at reset values immediately. A following 0x7E is received correctly.
